base_ram_arbiter: RTL and testbench



---
 rtl/base_ram_arbiter_if.sv | 39 +++
 rtl/base_ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_base_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/base_ram_arbiter_if.sv
// BaseRAM arbiter bus bundle: CPU fetch/data request ports plus the SRAM pin-side signals.
// The arbiter uses the slave modport; the CPU/top-level side uses master.
interface base_ram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  logic        stall_o;

  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [31:0] sram_wdata;
  logic        sram_data_oe;
  logic [31:0] sram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, sram_rdata,
    output if_done, if_rdata, mem_done, mem_rdata, stall_o,
    output sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata, sram_data_oe
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, sram_rdata,
    input  if_done, if_rdata, mem_done, mem_rdata, stall_o,
    input  sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata, sram_data_oe
  );
endinterface

// File: rtl/base_ram_arbiter.sv
// Single-port BaseRAM sequencer shared by instruction fetch and MEM-stage data accesses.
// One access at a time, programmable strobe length, registered read data per requester.
module base_ram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  base_ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StRd, StWrSetup, StWrPulse, StWrHold, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_mem_q, last_mem_d;
  logic        owner_mem_q, owner_mem_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic        grant_mem, grant_if;
  logic        ce_n, oe_n, we_n, data_oe, if_done, mem_done;
  logic [3:0]  be_n;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:22], bus.if_addr[1:0],
                              bus.mem_addr[31:22], bus.mem_addr[1:0]};

  // One-hot sel returns the addressed byte sign-extended; anything else is a word access.
  function automatic logic [31:0] extract(input logic [3:0] sel, input logic [31:0] word);
    case (sel)
      4'b0001: extract = {{24{word[7]}},  word[7:0]};
      4'b0010: extract = {{24{word[15]}}, word[15:8]};
      4'b0100: extract = {{24{word[23]}}, word[23:16]};
      4'b1000: extract = {{24{word[31]}}, word[31:24]};
      default: extract = word;
    endcase
  endfunction

  // MEM has priority unless it won last time and a fetch is waiting.
  assign grant_mem = bus.mem_req & ~(last_mem_q & bus.if_req);
  assign grant_if  = bus.if_req & ~grant_mem;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    owner_mem_d = owner_mem_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ce_n        = 1'b1;
    oe_n        = 1'b1;
    we_n        = 1'b1;
    be_n        = 4'hF;
    data_oe     = 1'b0;
    if_done     = 1'b0;
    mem_done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_mem) begin
          owner_mem_d = 1'b1;
          last_mem_d  = 1'b1;
          cnt_d       = 4'(WAIT_CYCLES);
          addr_d      = bus.mem_addr[21:2];
          sel_d       = bus.mem_sel;
          wdata_d     = bus.mem_wdata;
          state_d     = bus.mem_we ? StWrSetup : StRd;
        end else if (grant_if) begin
          owner_mem_d = 1'b0;
          last_mem_d  = 1'b0;
          cnt_d       = 4'(WAIT_CYCLES);
          addr_d      = bus.if_addr[21:2];
          sel_d       = 4'hF;
          state_d     = StRd;
        end
      end
      StRd: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
        be_n = ~sel_q;
        if (cnt_q == 4'd0) begin
          if (owner_mem_q) mem_rdata_d = extract(sel_q, bus.sram_rdata);
          else             if_rdata_d  = bus.sram_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrSetup: begin
        ce_n    = 1'b0;
        be_n    = ~sel_q;
        data_oe = 1'b1;
        state_d = StWrPulse;
      end
      StWrPulse: begin
        ce_n    = 1'b0;
        we_n    = 1'b0;
        be_n    = ~sel_q;
        data_oe = 1'b1;
        if (cnt_q == 4'd0) state_d = StWrHold;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StWrHold: begin
        // Bus still driven one cycle after we_n rises to meet SRAM data hold.
        ce_n    = 1'b0;
        be_n    = ~sel_q;
        data_oe = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        mem_done = owner_mem_q;
        if_done  = ~owner_mem_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      last_mem_q  <= 1'b0;
      owner_mem_q <= 1'b0;
      sel_q       <= 4'h0;
      wdata_q     <= 32'h0;
      addr_q      <= 20'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      owner_mem_q <= owner_mem_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.if_done      = if_done;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.mem_done     = mem_done;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.stall_o      = (bus.mem_req & ~mem_done) | (bus.if_req & ~if_done);
  assign bus.sram_addr    = addr_q;
  assign bus.sram_be_n    = be_n;
  assign bus.sram_ce_n    = ce_n;
  assign bus.sram_oe_n    = oe_n;
  assign bus.sram_we_n    = we_n;
  assign bus.sram_wdata   = wdata_q;
  assign bus.sram_data_oe = data_oe;

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Directed bench for base_ram_arbiter: W=1 instance with a small SRAM model, W=2 instance
// for the write strobe shape.
module tb_base_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  base_ram_arbiter_if i1 ();
  base_ram_arbiter_if i2 ();

  base_ram_arbiter #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  base_ram_arbiter #(.WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(i2.slave));

  // 16-word SRAM model behind dut1, with a bench preload port.
  logic [31:0] sram_mem [16] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [31:0] pre_data = 32'h0;

  assign i1.sram_rdata = sram_mem[i1.sram_addr[3:0]];
  assign i2.sram_rdata = 32'h0;

  always @(posedge clk) begin
    if (pre_en) begin
      sram_mem[pre_idx] <= pre_data;
    end else if (!i1.sram_ce_n && !i1.sram_we_n && i1.sram_data_oe) begin
      for (int b = 0; b < 4; b++)
        if (!i1.sram_be_n[b]) sram_mem[i1.sram_addr[3:0]][8*b +: 8] <= i1.sram_wdata[8*b +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int bus_viol = 0;

  always @(negedge clk) begin
    if ((!i1.sram_oe_n && i1.sram_data_oe) || (!i2.sram_oe_n && i2.sram_data_oe)) bus_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // One MEM access on dut1; done_cyc is -1 if no done within the budget.
  task automatic mem_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, output int done_cyc,
                            output logic [31:0] rdata, output logic [19:0] saddr,
                            output logic [3:0] be_n);
    @(posedge clk); #1;
    i1.mem_req = 1'b1; i1.mem_we = we; i1.mem_sel = sel;
    i1.mem_addr = addr; i1.mem_wdata = wdata;
    done_cyc = -1; rdata = 32'h0; saddr = 20'h0; be_n = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) begin saddr = i1.sram_addr; be_n = i1.sram_be_n; end
      if (i1.mem_done) begin done_cyc = c; rdata = i1.mem_rdata; break; end
    end
    @(posedge clk); #1;
    i1.mem_req = 1'b0; i1.mem_we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_word;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic [19:0] exp_saddr;
    logic [3:0]  exp_be_n;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          dc, m1, m2, f1, overlap, pulses, first_p, last_p;
    logic [31:0] rd, if_data, m1_data;
    logic [19:0] sa;
    logic [3:0]  be, w_be;
    logic        stall_c3, seen_done;
    logic        oe_hist [10];
    logic        we_hist [10];

    vecs[0] = '{1'b0, 4'b0100, 32'h8000_0000, 32'h0, 1'b1, 32'h12F4_5678, 32'hFFFF_FFF4, 3, 20'h0, 4'b1011};
    vecs[1] = '{1'b0, 4'b0010, 32'h8000_0000, 32'h0, 1'b0, 32'h0,         32'h0000_0056, 3, 20'h0, 4'b1101};
    vecs[2] = '{1'b0, 4'b0001, 32'h8040_0008, 32'h0, 1'b1, 32'h12F4_5680, 32'hFFFF_FF80, 3, 20'h2, 4'b1110};
    vecs[3] = '{1'b0, 4'b1000, 32'h8040_0008, 32'h0, 1'b0, 32'h0,         32'h0000_0012, 3, 20'h2, 4'b0111};
    vecs[4] = '{1'b0, 4'b1111, 32'h8040_0008, 32'h0, 1'b0, 32'h0,         32'h12F4_5680, 3, 20'h2, 4'b0000};
    vecs[5] = '{1'b0, 4'b0011, 32'h8040_0008, 32'h0, 1'b0, 32'h0,         32'h12F4_5680, 3, 20'h2, 4'b1100};
    vecs[6] = '{1'b1, 4'b0011, 32'h8000_0004, 32'hAABB_CCDD, 1'b1, 32'h1122_3344, 32'h12F4_5680, 5, 20'h1, 4'b1100};
    vecs[7] = '{1'b0, 4'b1111, 32'h8000_0004, 32'h0, 1'b0, 32'h0,         32'h1122_CCDD, 3, 20'h1, 4'b0000};
    vecs[8] = '{1'b0, 4'b1000, 32'h8000_0004, 32'h0, 1'b0, 32'h0,         32'h0000_0011, 3, 20'h1, 4'b0111};

    rst = 1'b1;
    i1.if_req = 0; i1.if_addr = 0; i1.mem_req = 0; i1.mem_we = 0; i1.mem_sel = 0;
    i1.mem_addr = 0; i1.mem_wdata = 0;
    i2.if_req = 0; i2.if_addr = 0; i2.mem_req = 0; i2.mem_we = 0; i2.mem_sel = 0;
    i2.mem_addr = 0; i2.mem_wdata = 0;
    #3;
    check("reset strobes", {i1.sram_ce_n, i1.sram_oe_n, i1.sram_we_n, i1.sram_data_oe}, 4'b1110);
    check("reset be_n", i1.sram_be_n, 4'hF);
    check("reset sram_addr", i1.sram_addr, 20'h0);
    check("reset done", {i1.if_done, i1.mem_done}, 2'b00);
    check("reset if_rdata", i1.if_rdata, 32'h0);
    check("reset mem_rdata", i1.mem_rdata, 32'h0);
    check("reset stall", i1.stall_o, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Fetch read, W=1.
    preload(4'h4, 32'h3C01_0001);
    @(posedge clk); #1;
    i1.if_req = 1'b1; i1.if_addr = 32'h8000_0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c < 3) check($sformatf("fetch stall c%0d", c), i1.stall_o, 1'b1);
      if (c == 1 || c == 2) begin
        check($sformatf("fetch addr c%0d", c), i1.sram_addr, 20'h00004);
        check($sformatf("fetch oe_n c%0d", c), {i1.sram_oe_n, i1.sram_ce_n, i1.sram_we_n}, 3'b001);
        check($sformatf("fetch be_n c%0d", c), i1.sram_be_n, 4'h0);
      end
      check($sformatf("fetch if_done c%0d", c), i1.if_done, c == 3);
    end
    check("fetch if_rdata", i1.if_rdata, 32'h3C01_0001);
    check("fetch stall at done", i1.stall_o, 1'b0);
    @(posedge clk); #1;
    i1.if_req = 1'b0;

    // Contention: MEM first, then IF via last_mem, then MEM again.
    preload(4'h0, 32'h12F4_5678);
    preload(4'h5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    i1.mem_req = 1'b1; i1.mem_we = 1'b0; i1.mem_sel = 4'hF; i1.mem_addr = 32'h8000_0000;
    i1.if_req = 1'b1; i1.if_addr = 32'h8000_0014;
    m1 = -1; m2 = -1; f1 = -1; overlap = 0; if_data = 0; m1_data = 0; stall_c3 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i1.mem_done && i1.if_done) overlap++;
      if (i1.mem_done) begin
        if (m1 < 0) begin m1 = c; m1_data = i1.mem_rdata; end
        else m2 = c;
      end
      if (i1.if_done) begin f1 = c; if_data = i1.if_rdata; end
      if (c == 3) stall_c3 = i1.stall_o;
    end
    @(posedge clk); #1;
    i1.mem_req = 1'b0; i1.if_req = 1'b0;
    check("contention first mem_done", m1, 3);
    check("contention mem data", m1_data, 32'h12F4_5678);
    check("contention if_done", f1, 7);
    check("contention if data", if_data, 32'hDEAD_BEEF);
    check("contention second mem_done", m2, 11);
    check("contention overlap", overlap, 0);
    check("contention stall c3", stall_c3, 1'b1);

    // Table of MEM accesses on the W=1 instance.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].pre) preload(vecs[i].addr[5:2], vecs[i].pre_word);
      mem_access(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata, dc, rd, sa, be);
      check($sformatf("vec%0d done cycle", i), dc, vecs[i].exp_cyc);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d sram_addr", i), sa, vecs[i].exp_saddr);
      check($sformatf("vec%0d be_n", i), be, vecs[i].exp_be_n);
    end

    // W=2 write strobe shape on the second instance.
    for (int c = 0; c < 10; c++) begin oe_hist[c] = 1'b0; we_hist[c] = 1'b0; end
    pulses = 0; first_p = -1; last_p = -1; dc = -1; w_be = 4'h0;
    @(posedge clk); #1;
    i2.mem_req = 1'b1; i2.mem_we = 1'b1; i2.mem_sel = 4'b0011;
    i2.mem_addr = 32'h8000_0008; i2.mem_wdata = 32'hAABB_CCDD;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      oe_hist[c] = i2.sram_data_oe;
      we_hist[c] = i2.sram_we_n;
      if (!i2.sram_we_n) begin pulses++; if (first_p < 0) first_p = c; last_p = c; end
      if (c == 1) w_be = i2.sram_be_n;
      if (i2.mem_done) begin dc = c; break; end
    end
    check("w2 wdata", i2.sram_wdata, 32'hAABB_CCDD);
    @(posedge clk); #1;
    i2.mem_req = 1'b0; i2.mem_we = 1'b0;
    check("w2 be_n", w_be, 4'b1100);
    check("w2 pulse length", pulses, 3);
    check("w2 pulse start", first_p, 2);
    check("w2 pulse end", last_p, 4);
    check("w2 setup cycle", {oe_hist[1], we_hist[1]}, 2'b11);
    check("w2 hold cycle", {oe_hist[5], we_hist[5]}, 2'b11);
    check("w2 done cycle", dc, 6);
    check("w2 bus released at done", oe_hist[6], 1'b0);

    // Reset asserted during WR_PULSE.
    @(posedge clk); #1;
    i1.mem_req = 1'b1; i1.mem_we = 1'b1; i1.mem_sel = 4'hF;
    i1.mem_addr = 32'h8000_000C; i1.mem_wdata = 32'h55AA_55AA;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("rstmid in pulse", i1.sram_we_n, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rstmid strobes async", {i1.sram_we_n, i1.sram_data_oe, i1.sram_ce_n}, 3'b101);
    check("rstmid mem_done", i1.mem_done, 1'b0);
    i1.mem_req = 1'b0; i1.mem_we = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (i1.mem_done) seen_done = 1'b1;
    end
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (i1.mem_done || !i1.sram_ce_n) seen_done = 1'b1;
    end
    check("rstmid quiet after reset", seen_done, 1'b0);
    check("rstmid mem_rdata cleared", i1.mem_rdata, 32'h0);
    mem_access(1'b0, 4'hF, 32'h8000_0000, 32'h0, dc, rd, sa, be);
    check("post-reset read done", dc, 3);
    check("post-reset read data", rd, 32'h12F4_5678);

    check("bus safety", bus_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
